instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The port list SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset_n  input  1  async active-low reset
- in_valid  input  1  request carries an instruction
- in_ready  output  1  block accepts the request this cycle
- in_type  input  6  type code: 1 ADDU, 2 SUBU, 3 ORI, 4 LW, 5 SW, 6 BEQ, 7 LUI, 8 J, 9 JAL, 10 JR, 11 SLT
- in_rs, in_rt, in_rd  input  5 each  register fields
- in_imm  input  16  immediate or branch offset
- in_target  input  26  jump target field
- out_valid  output  1  out_instr/out_addr hold a valid entry
- out_ready  input  1  consumer takes the entry
- out_instr  output  32  encoded MIPS word
- out_addr  output  32  word address of out_instr
- emit_cnt  output  16  number of words emitted
- err  output  1  sticky illegal-type flag

Function
REQ-003 The encodings SHALL be as follows:
- ADDU/SUBU/SLT: op 0, rs, rt, rd, shamt 0, funct 0x21/0x23/0x2A.
- JR: op 0, rs, other fields 0, funct 0x08.
- ORI/LW/SW/BEQ: op 0x0D/0x23/0x2B/0x04, rs, rt, imm.
- LUI: op 0x0F, rs 0, rt, imm.
- J/JAL: op 0x02/0x03, target.
REQ-004 Fields that are unused by the selected type SHALL be ignored; they are forced to 0 and never leak into out_instr.
REQ-005 Input handshake: a request is accepted when in_valid && in_ready at a rising edge.
REQ-006 The block SHALL hold a 2-entry output FIFO; in_ready = (occupancy < 2), computed combinationally from registered occupancy only.
REQ-007 Latency: an accepted word SHALL appear on out_instr with out_valid=1 in the cycle after acceptance when the FIFO was empty.
REQ-008 Output handshake: an entry is emitted when out_valid && out_ready. out_instr/out_addr SHALL stay stable while out_valid && !out_ready.
REQ-009 Simultaneous accept and emit with occupancy 2 SHALL NOT occur (in_ready=0). At occupancy 1 both SHALL happen in the same cycle, and occupancy stays 1.
REQ-010 Address counter:
- starts at 0x0000_3000;
- is captured into the entry at acceptance;
- increments by 4 per accepted legal word;
- wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-011 emit_cnt SHALL increment by 1 per emitted entry and saturate at 0xFFFF.
REQ-012 An illegal type (0 or >11) SHALL be handled per REQ-016/REQ-017.

Reset
REQ-013 Asserting reset_n low SHALL immediately produce:
- FIFO empty, out_valid=0, in_ready=1;
- out_instr=0, out_addr=0;
- address counter = 0x0000_3000;
- emit_cnt=0, err=0.
REQ-014 Reset mid-transfer SHALL discard all buffered entries with no partial emission. The first request after release is accepted at address 0x0000_3000.

Configuration
REQ-015 The macro INSTR_ENC_CHECK_EN SHALL select how illegal types are handled.
REQ-016 With INSTR_ENC_CHECK_EN defined, an illegal-type request:
- is accepted (in_ready unchanged) but dropped, with no FIFO write;
- leaves the address counter unchanged;
- sets err=1 on the next edge, and err holds until reset.
REQ-017 Without INSTR_ENC_CHECK_EN, an illegal-type request:
- is encoded as 0x0000_0000 (nop), enqueued, and advances the address;
- err is tied to 0.

Verification
REQ-018 Reset then ADDU rs=1 rt=2 rd=3 -> next cycle out_instr=0x00221821, out_addr=0x00003000.
REQ-019 Back-to-back ORI rt=5 rs=0 imm=0x1234, LUI rt=1 imm=0xABCD with out_ready=0 -> in_ready drops after two accepts; the FIFO holds 0x34051234 @0x3000 and 0x3C01ABCD @0x3004; raising out_ready emits both in order and emit_cnt=2.
REQ-020 JAL target=0x0000C00 -> 0x0C000C00. BEQ rs=1 rt=2 imm=0xFFFF with in_rd=7 -> 0x1022FFFF. JR rs=31 with nonzero rt/rd/imm -> 0x03E00008.
REQ-021 in_type=12 -> with INSTR_ENC_CHECK_EN: err=1, nothing emitted, next legal word at the unchanged address. Without it: 0x00000000 emitted and the address advances by 4.
REQ-022 Force the address counter to 0xFFFFFFFC, then send two words -> out_addr values 0xFFFFFFFC and 0x00000000.
REQ-023 Assert reset_n low with 2 entries buffered and out_ready=0 -> out_valid=0 immediately; after release, the next word is at 0x3000 and emit_cnt=0.

Source files
------------

// File: rtl/instr_encoder.sv
// MIPS instruction encoder with a 2-entry output FIFO and word-address stamping.
// Define INSTR_ENC_CHECK_EN to drop illegal types and flag them on err.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_type,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] emit_cnt,
  output logic        err
);

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  logic [31:0] instr0_q, instr0_d;
  logic [31:0] instr1_q, instr1_d;
  logic [31:0] addr0_q, addr0_d;
  logic [31:0] addr1_q, addr1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] emit_cnt_q, emit_cnt_d;
  logic        err_q, err_d;

  logic [31:0] enc;
  logic        legal;
  logic        acc;
  logic        push;
  logic        pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = instr0_q;
  assign out_addr  = addr0_q;
  assign emit_cnt  = emit_cnt_q;
  assign err       = err_q;

  // Only the fields a type uses are placed; the rest stay zero.
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    unique case (1'b1)
      (in_type == 6'd1):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      (in_type == 6'd2):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      (in_type == 6'd3):
        enc = {6'h0D, in_rs, in_rt, in_imm};
      (in_type == 6'd4):
        enc = {6'h23, in_rs, in_rt, in_imm};
      (in_type == 6'd5):
        enc = {6'h2B, in_rs, in_rt, in_imm};
      (in_type == 6'd6):
        enc = {6'h04, in_rs, in_rt, in_imm};
      (in_type == 6'd7):
        enc = {6'h0F, 5'd0, in_rt, in_imm};
      (in_type == 6'd8):
        enc = {6'h02, in_target};
      (in_type == 6'd9):
        enc = {6'h03, in_target};
      (in_type == 6'd10):
        enc = {6'h00, in_rs, 15'd0, 6'h08};
      (in_type == 6'd11):
        enc = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      default:
        legal = 1'b0;
    endcase
  end

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

`ifdef INSTR_ENC_CHECK_EN
  assign push  = acc && legal;
  assign err_d = err_q | (acc && !legal);
`else
  assign push  = acc;
  assign err_d = 1'b0;
`endif

  always_comb begin
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    pc_d       = pc_q;
    emit_cnt_d = emit_cnt_q;
    if (pop) begin
      instr0_d = instr1_q;
      addr0_d  = addr1_q;
      if (emit_cnt_q != 16'hFFFF) begin
        emit_cnt_d = emit_cnt_q + 16'd1;
      end
    end
    // A push lands at the head if the head is free after this cycle's pop.
    if (push) begin
      pc_d = pc_q + 32'd4;
      if ((cnt_q == 2'd0) || pop) begin
        instr0_d = enc;
        addr0_d  = pc_q;
      end else begin
        instr1_d = enc;
        addr1_d  = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr0_q   <= '0;
      instr1_q   <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      cnt_q      <= '0;
      pc_q       <= PC_RST;
      emit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      emit_cnt_q <= emit_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule
